// File: rtl/msk_g4mul_hpc1_sched_if.sv
// Requester-side bundle of the masked G(4) multiplier scheduler.
//   req_valid/req_ready : per-requester handshake (requester i in bit i)
//   req_a0/a1/b0/b1     : operand sharings, requester i in slice [i*D +: D]
//   rnd_valid/rnd_ready : PRNG word handshake
//   rnd_data            : low RND_REF_W bits -> refresh, upper bits -> DOM
//   resp_valid          : one-hot result strobe, bit i for requester i
//   resp_out0/1         : result sharings of bit 0 / bit 1
// master = requesters + PRNG, slave = scheduler.
interface msk_g4mul_hpc1_sched_if #(
  parameter int D         = 2,
  parameter int RND_REF_W = 2,
  parameter int RND_MUL_W = 2
);
  logic [1:0]                     req_valid;
  logic [1:0]                     req_ready;
  logic [2*D-1:0]                 req_a0;
  logic [2*D-1:0]                 req_a1;
  logic [2*D-1:0]                 req_b0;
  logic [2*D-1:0]                 req_b1;
  logic                           rnd_valid;
  logic                           rnd_ready;
  logic [RND_REF_W+RND_MUL_W-1:0] rnd_data;
  logic [1:0]                     resp_valid;
  logic [D-1:0]                   resp_out0;
  logic [D-1:0]                   resp_out1;

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, rnd_valid, rnd_data,
    input  req_ready, rnd_ready, resp_valid, resp_out0, resp_out1
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, rnd_valid, rnd_data,
    output req_ready, rnd_ready, resp_valid, resp_out0, resp_out1
  );
endinterface

// File: rtl/msk_g4mul_hpc1_sched.sv
// Two-requester round-robin scheduler in front of one pipelined masked HPC1
// G(4) multiplier. One operation may issue per cycle when a PRNG word is
// available; operand shares and randomness are skewed so each reaches the
// gadget at its own latency, and a valid/id pipeline routes results back.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   bus                  : requester/PRNG handshake bundle (slave side)
//   mul_ina0/1, inb0/1   : gadget operand shares (bit 0 / bit 1 sharings)
//   mul_rnd_ref          : refresh randomness, same cycle as issue
//   mul_rnd_mul          : DOM randomness, aligned with the a shares
//   mul_out0/1           : gadget result shares
//   inflight             : operations currently in the gadget pipeline
module msk_g4mul_hpc1_sched #(
  parameter int D         = 2,
  parameter int REF_LAT   = 1,
  parameter int RND_REF_W = 2,
  parameter int RND_MUL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  msk_g4mul_hpc1_sched_if.slave bus,
  output logic [D-1:0]         mul_ina0,
  output logic [D-1:0]         mul_ina1,
  output logic [D-1:0]         mul_inb0,
  output logic [D-1:0]         mul_inb1,
  output logic [RND_REF_W-1:0] mul_rnd_ref,
  output logic [RND_MUL_W-1:0] mul_rnd_mul,
  input  logic [D-1:0]         mul_out0,
  input  logic [D-1:0]         mul_out1,
  output logic [2:0]           inflight
);

  localparam int A_STAGES   = REF_LAT + 1;
  localparam int RSP_STAGES = REF_LAT + 2;

  typedef struct packed {
    logic [D-1:0]         a0;
    logic [D-1:0]         a1;
    logic [RND_MUL_W-1:0] rnd_mul;
  } a_slot_t;

  typedef struct packed {
    logic [D-1:0] b0;
    logic [D-1:0] b1;
  } b_slot_t;

  typedef struct packed {
    logic vld;
    logic id;
  } rsp_slot_t;

  logic      r_prio;      // requester that wins when both are valid
  logic [2:0] r_inflight;
  logic      w_issue;
  logic      w_win;
  a_slot_t   w_a_in;
  b_slot_t   w_b_in;
  b_slot_t   w_b_out;
  rsp_slot_t w_rsp;

  a_slot_t   r_a_dl   [A_STAGES];
  rsp_slot_t r_rsp_dl [RSP_STAGES];

  // Gating with rst_n keeps every handshake output low during reset even
  // though the state registers only clear on the next edge.
  assign w_issue = rst_n & bus.rnd_valid & (|bus.req_valid);
  assign w_win   = (&bus.req_valid) ? r_prio : bus.req_valid[1];

  assign bus.req_ready = w_issue ? (2'b01 << w_win) : 2'b00;
  assign bus.rnd_ready = w_issue;
  assign mul_rnd_ref   = w_issue ? bus.rnd_data[RND_REF_W-1:0] : '0;

  // Non-issue slots inject zeros at the head of every delay line, so a
  // bubble reaches the gadget as all-zero inputs and no share is replayed.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_a_in = '0;
    w_b_in = '0;
    if (w_issue) begin
      w_a_in.a0      = w_win ? bus.req_a0[2*D-1:D] : bus.req_a0[D-1:0];
      w_a_in.a1      = w_win ? bus.req_a1[2*D-1:D] : bus.req_a1[D-1:0];
      w_a_in.rnd_mul = bus.rnd_data[RND_REF_W +: RND_MUL_W];
      w_b_in.b0      = w_win ? bus.req_b0[2*D-1:D] : bus.req_b0[D-1:0];
      w_b_in.b1      = w_win ? bus.req_b1[2*D-1:D] : bus.req_b1[D-1:0];
    end
  end

  // a shares and DOM randomness: 1+REF_LAT register stages.
  // NOTE: the delay lines are reset explicitly; they carry shares, and a
  // reset that left them populated would replay secrets into the gadget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < A_STAGES; i++) r_a_dl[i] <= '0;
    end else begin
      r_a_dl[0] <= w_a_in;
      for (int i = 1; i < A_STAGES; i++) r_a_dl[i] <= r_a_dl[i-1];
    end
  end

  // b shares: REF_LAT register stages, a plain wire when REF_LAT is 0.
  generate
    if (REF_LAT == 0) begin : g_b_comb
      assign w_b_out = w_b_in;
    end else begin : g_b_reg
      b_slot_t r_b_dl [REF_LAT];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < REF_LAT; i++) r_b_dl[i] <= '0;
        end else begin
          r_b_dl[0] <= w_b_in;
          for (int i = 1; i < REF_LAT; i++) r_b_dl[i] <= r_b_dl[i-1];
        end
      end
      assign w_b_out = r_b_dl[REF_LAT-1];
    end
  endgenerate

  assign mul_ina0    = r_a_dl[A_STAGES-1].a0;
  assign mul_ina1    = r_a_dl[A_STAGES-1].a1;
  assign mul_rnd_mul = r_a_dl[A_STAGES-1].rnd_mul;
  assign mul_inb0    = w_b_out.b0;
  assign mul_inb1    = w_b_out.b1;

  // Valid/id pipeline: the last stage lines up with the gadget output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_STAGES; i++) r_rsp_dl[i] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every stage
      // reads its neighbour's pre-edge value, giving a true shift register.
      r_rsp_dl[0] <= '{vld: w_issue, id: w_win};
      for (int i = 1; i < RSP_STAGES; i++) r_rsp_dl[i] <= r_rsp_dl[i-1];
    end
  end

  assign w_rsp          = r_rsp_dl[RSP_STAGES-1];
  assign bus.resp_valid = (rst_n && w_rsp.vld) ? (2'b01 << w_rsp.id) : 2'b00;
  assign bus.resp_out0  = mul_out0;
  assign bus.resp_out1  = mul_out1;

  // Arbitration pointer and occupancy counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio     <= 1'b0;
      r_inflight <= '0;
    end else begin
      if (w_issue) r_prio <= ~w_win;
      if (w_issue && !w_rsp.vld)      r_inflight <= r_inflight + 3'd1;
      else if (!w_issue && w_rsp.vld) r_inflight <= r_inflight - 3'd1;
    end
  end

  assign inflight = r_inflight;

endmodule
